// File: rtl/offset_scan_ctrl.sv
// rtl/offset_scan_ctrl.sv - RX sampling-offset sweep: per-phase BER measurement, lock on the best phase
// All outputs are registered from the next state so they change together with the state.
module offset_scan_ctrl #(
   parameter int OS      = 4,
   parameter int NB_OFS  = 2,
   parameter int NB_CNT  = 64,
   parameter int WINDOW  = 511,
   parameter int SETTLE  = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_valid,
   input  logic              i_start,
   input  logic [NB_CNT-1:0] i_errors,
   input  logic [NB_CNT-1:0] i_bits,
   output logic [NB_OFS-1:0] o_offset,
   output logic              o_ber_clear,
   output logic              o_ber_enable,
   output logic              o_busy,
   output logic              o_locked,
   output logic              o_fail,
   output logic [NB_CNT-1:0] o_best_errors
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0]     SETTLE_END  = SW'(SETTLE);
   localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [TW-1:0]     TIMEOUT_END = TW'(TIMEOUT);
   localparam logic [NB_OFS-1:0] LAST_OFS    = NB_OFS'(OS - 1);
   localparam logic [NB_CNT-1:0] WINDOW_CNT  = NB_CNT'(WINDOW);

   typedef enum logic [2:0] {IDLE, CLEAR, SETTLE_ST, MEASURE, EVAL, APPLY, LOCKED} state_t;

   state_t            state, state_d;
   logic [NB_OFS-1:0] cur_ofs, cur_ofs_d, best_ofs, best_ofs_d;
   logic [NB_CNT-1:0] best_err, best_err_d;
   logic [SW-1:0]     settle_cnt, settle_cnt_d;
   logic [TW-1:0]     to_cnt, to_cnt_d;
   logic              to_flag, to_flag_d;
   logic              settle_hit, new_best, have_best;
   logic [NB_OFS-1:0] offset_d;
   logic              clear_d, enable_d, busy_d, locked_d, fail_d;
   logic [NB_CNT-1:0] best_out_d;

   assign new_best  = (state == EVAL) && !to_flag && (i_errors < best_err);
   assign have_best = ~&best_err_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cur_ofs       <= '0;
         best_ofs      <= '0;
         best_err      <= '1;
         settle_cnt    <= '0;
         to_cnt        <= '0;
         to_flag       <= 1'b0;
         o_offset      <= '0;
         o_ber_clear   <= 1'b0;
         o_ber_enable  <= 1'b0;
         o_busy        <= 1'b0;
         o_locked      <= 1'b0;
         o_fail        <= 1'b0;
         o_best_errors <= '1;
      end else begin
         state         <= state_d;
         cur_ofs       <= cur_ofs_d;
         best_ofs      <= best_ofs_d;
         best_err      <= best_err_d;
         settle_cnt    <= settle_cnt_d;
         to_cnt        <= to_cnt_d;
         to_flag       <= to_flag_d;
         o_offset      <= offset_d;
         o_ber_clear   <= clear_d;
         o_ber_enable  <= enable_d;
         o_busy        <= busy_d;
         o_locked      <= locked_d;
         o_fail        <= fail_d;
         o_best_errors <= best_out_d;
      end
   end

   always_comb begin
      state_d      = state;
      cur_ofs_d    = cur_ofs;
      best_ofs_d   = best_ofs;
      best_err_d   = best_err;
      settle_cnt_d = settle_cnt;
      to_cnt_d     = to_cnt;
      to_flag_d    = to_flag;
      settle_hit   = 1'b0;
      case (state)
         IDLE, LOCKED: begin
            if (i_start) begin
               state_d    = CLEAR;
               cur_ofs_d  = '0;
               best_ofs_d = '0;
               best_err_d = '1;
            end
         end
         CLEAR: begin
            settle_cnt_d = '0;
            state_d      = SETTLE_ST;
         end
         SETTLE_ST: begin
            // The strobe that completes the settle count triggers the second clear;
            // MEASURE is entered the cycle after that clear pulse.
            if (settle_cnt == SETTLE_END) begin
               to_cnt_d = '0;
               state_d  = MEASURE;
            end else if (i_valid) begin
               settle_cnt_d = settle_cnt + SW'(1);
               settle_hit   = (settle_cnt == SETTLE_LAST);
            end
         end
         MEASURE: begin
            if (i_bits >= WINDOW_CNT) begin
               to_flag_d = 1'b0;
               state_d   = EVAL;
            end else if (to_cnt == TIMEOUT_END) begin
               to_flag_d = 1'b1;
               state_d   = EVAL;
            end else if (i_valid) begin
               to_cnt_d = to_cnt + TW'(1);
            end
         end
         EVAL: begin
            if (new_best) begin
               best_err_d = i_errors;
               best_ofs_d = cur_ofs;
            end
            if (cur_ofs == LAST_OFS) begin
               state_d = APPLY;
            end else begin
               cur_ofs_d = cur_ofs + NB_OFS'(1);
               state_d   = CLEAR;
            end
         end
         APPLY:   state_d = (&best_err) ? IDLE : LOCKED;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      offset_d   = '0;
      clear_d    = 1'b0;
      enable_d   = 1'b0;
      busy_d     = 1'b0;
      locked_d   = 1'b0;
      fail_d     = o_fail;
      best_out_d = new_best ? i_errors : o_best_errors;
      case (state_d)
         CLEAR, SETTLE_ST, MEASURE, EVAL: begin
            busy_d   = 1'b1;
            offset_d = cur_ofs_d;
         end
         APPLY: begin
            busy_d   = 1'b1;
            offset_d = have_best ? best_ofs_d : '0;
            clear_d  = have_best;
         end
         LOCKED: begin
            locked_d = 1'b1;
            enable_d = 1'b1;
            offset_d = best_ofs_d;
         end
         default: offset_d = '0;
      endcase
      if (state_d == CLEAR || settle_hit)
         clear_d = 1'b1;
      if (state_d == MEASURE)
         enable_d = 1'b1;
      if (state_d == CLEAR && (state == IDLE || state == LOCKED))
         fail_d = 1'b0;
      if (state == APPLY && state_d == IDLE)
         fail_d = 1'b1;
   end

endmodule

// File: doc/offset_scan_ctrl.md
# offset_scan_ctrl

Automatic receive-sampling-phase controller for the PRBS9/BPSK/RC/BER link. On start, it sweeps the RX sampling offset over all OS phases. At each phase it clears the BER counter, waits a settle interval, and measures errors over a fixed bit window. It then selects the phase with the fewest errors and locks the RX offset there with BER counting running continuously. It sits between the switch/VIO control logic and the RX offset mux / BER block, and replaces manual offset selection when enabled.

## Interface
- OS, 4: oversampling factor; number of offsets scanned.
- NB_OFS, 2: offset width; must satisfy 2^NB_OFS >= OS.
- NB_CNT, 64: width of BER error/bit counters.
- WINDOW, 511: bits per measurement; measurement ends when i_bits >= WINDOW.
- SETTLE, 16: i_valid strobes waited after clear before measuring.
- TIMEOUT, 4096: maximum i_valid strobes in MEASURE before the phase is abandoned.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_valid  in  1  symbol-rate strobe, one clock wide
- i_start  in  1  level/pulse; starts a scan when sampled high in IDLE or LOCKED
- i_errors  in  NB_CNT  BER block error count
- i_bits  in  NB_CNT  BER block compared-bit count
- o_offset  out  NB_OFS  RX sampling offset to the sample mux
- o_ber_clear  out  1  one-cycle synchronous clear of the BER counters
- o_ber_enable  out  1  BER accumulate enable; BER uses i_valid && o_ber_enable
- o_busy  out  1  scan in progress
- o_locked  out  1  best offset applied
- o_fail  out  1  every offset timed out; sticky until next start or reset
- o_best_errors  out  NB_CNT  error count of the chosen offset

## Operation
- States: IDLE, CLEAR, SETTLE, MEASURE, EVAL, APPLY, LOCKED.
- IDLE → CLEAR on i_start. On this transition: cur_ofs=0, best_err=all ones, best_ofs=0, o_fail=0.
- CLEAR (1 cycle):
  - o_ber_clear=1, o_ber_enable=0, o_offset=cur_ofs.
  - Settle counter := 0.
  - → SETTLE.
- SETTLE:
  - o_ber_enable=0; counts i_valid strobes.
  - After SETTLE strobes, pulse o_ber_clear once more (1 cycle), zero the timeout counter, → MEASURE.
- MEASURE:
  - o_ber_enable=1; counts i_valid strobes.
  - → EVAL when i_bits >= WINDOW, or when the timeout count reaches TIMEOUT. Record the reason in to_flag.
- EVAL (1 cycle):
  - o_ber_enable=0.
  - If !to_flag and i_errors < best_err (strict), then best_err := i_errors and best_ofs := cur_ofs. Ties keep the lower offset.
  - If cur_ofs == OS-1 → APPLY; else cur_ofs+1 → CLEAR.
- APPLY (1 cycle):
  - If best_err is still all ones (all timed out): o_fail=1, o_offset=0, → IDLE.
  - Else: o_offset := best_ofs, o_ber_clear=1, → LOCKED.
- LOCKED:
  - o_locked=1, o_ber_enable=1, o_offset=best_ofs held.
  - i_start → CLEAR with a new scan (same init as from IDLE).
- i_start is ignored while o_busy.
- o_best_errors updates only in EVAL on a new best, and holds in LOCKED/IDLE.
- o_busy=1 in CLEAR, SETTLE, MEASURE, EVAL, APPLY.

## Timing
- Reset values:
  - State=IDLE.
  - o_offset=0, o_ber_clear=0, o_ber_enable=0, o_busy=0, o_locked=0, o_fail=0.
  - o_best_errors=all ones.
- All outputs are registered; each reflects the state one clock after the transition decision.
- Start latency: i_start high at edge N gives o_busy=1 and o_ber_clear=1 at edge N+1.
- Offset change to first clear: the offset changes in CLEAR, and the BER is cleared again after settling. Errors from the previous phase's pipeline therefore never reach a measurement.
- i_bits/i_errors are sampled in the cycle state=EVAL. The BER block must present updated counts one cycle after its last enabled strobe; EVAL follows MEASURE exit by 1 cycle with enable already low.
- i_valid coincident with the MEASURE exit condition is not counted by the controller. BER-side counting of that strobe is permitted.
- Reset mid-scan: asynchronously returns to IDLE with all outputs at reset values. No partial result is retained.
- Nominal scan length ≈ OS×(SETTLE+WINDOW+2) strobes plus 4 clocks per phase.

## Test plan
- Ideal channel (BER reports 0 errors at offset 2, 100 errors elsewhere; WINDOW=511) → after the scan, o_offset=2, o_locked=1, o_best_errors=0, o_fail=0.
- Tie: offsets 1 and 3 both report 5 errors, the others 50 → o_offset=1 (lower wins), o_best_errors=5.
- Timeout: i_bits held at 0 for every offset → each phase exits after exactly TIMEOUT strobes; o_fail=1, o_locked=0, o_offset=0, state IDLE.
- Restart: i_start in LOCKED → o_locked drops next cycle and o_ber_clear pulses; a rescan in which offset 0 is best locks at 0. i_start during MEASURE has no effect.
- Reset mid-MEASURE at offset 1 → all outputs return to reset values immediately; a later i_start begins at offset 0.
- Clear/enable sequencing per phase: exactly two o_ber_clear pulses, and o_ber_enable is high only in MEASURE; check o_ber_enable is never high while o_ber_clear=1.
